// File: rtl/mult_pass_sequencer.sv
// Multi-pass multiply sequencer: steps dir/dir_counter over NUM_PASSES x PASS_LEN beats, then strobes data_done.
// stall freezes the sequence and abort cancels the job. SEQ_AUTO_RESTART_EN lets DONE start the next job directly.
module mult_pass_sequencer #(
  parameter int NUM_PASSES = 4,
  parameter int PASS_LEN   = 36,
  localparam int DIR_W     = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1,
  localparam int CNT_W     = (PASS_LEN > 1) ? $clog2(PASS_LEN) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             data_rdy,
  input  logic             stall,
  input  logic             abort,
  output logic [DIR_W-1:0] dir,
  output logic [CNT_W-1:0] dir_counter,
  output logic             mult_en,
  output logic             pass_done,
  output logic             data_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_PASSES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PASS_LEN - 1);

  state_t           state, state_nxt;
  logic [DIR_W-1:0] dir_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_nxt;

  assign mult_en   = (state == RUN) && !stall && !abort;
  assign pass_done = mult_en && (dir_counter == LAST_CNT);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    cnt_nxt   = dir_counter;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      dir_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          dir_nxt = '0;
          cnt_nxt = '0;
          if (data_rdy) state_nxt = RUN;
        end
        RUN: begin
          if (mult_en) begin
            if (dir_counter != LAST_CNT) begin
              cnt_nxt = dir_counter + CNT_W'(1);
            end else if (dir != LAST_DIR) begin
              cnt_nxt = '0;
              dir_nxt = dir + DIR_W'(1);
            end else begin
              // last beat of the last pass: data_done is registered so it lines up with DONE
              state_nxt = DONE;
              dir_nxt   = '0;
              cnt_nxt   = '0;
              done_nxt  = 1'b1;
            end
          end
        end
        DONE: begin
          state_nxt = IDLE;
          dir_nxt   = '0;
          cnt_nxt   = '0;
`ifdef SEQ_AUTO_RESTART_EN
          if (data_rdy) state_nxt = RUN;
`else
`endif
        end
        default: begin
          state_nxt = IDLE;
          dir_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dir         <= '0;
      dir_counter <= '0;
      data_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      dir         <= dir_nxt;
      dir_counter <= cnt_nxt;
      data_done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mult_pass_sequencer.sv
// Scoreboard bench for mult_pass_sequencer: a 4x36 instance and a 3x1 instance on a shared clock and reset.
module tb_mult_pass_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       data_rdy, stall, abort;
  logic [1:0] dir;
  logic [5:0] dir_counter;
  logic       mult_en, pass_done, data_done, busy;

  logic       s_rdy, s_stall, s_abort;
  logic [1:0] s_dir;
  logic [0:0] s_cnt;
  logic       s_men, s_pd, s_dd, s_busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] d;
    logic [5:0] c;
    logic       pd;
  } beat_t;

  beat_t sb[$];

  always #5 clk = ~clk;

  mult_pass_sequencer #(.NUM_PASSES(4), .PASS_LEN(36)) dut (
    .clk(clk), .reset_n(reset_n), .data_rdy(data_rdy), .stall(stall), .abort(abort),
    .dir(dir), .dir_counter(dir_counter), .mult_en(mult_en), .pass_done(pass_done),
    .data_done(data_done), .busy(busy)
  );

  mult_pass_sequencer #(.NUM_PASSES(3), .PASS_LEN(1)) dut_small (
    .clk(clk), .reset_n(reset_n), .data_rdy(s_rdy), .stall(s_stall), .abort(s_abort),
    .dir(s_dir), .dir_counter(s_cnt), .mult_en(s_men), .pass_done(s_pd),
    .data_done(s_dd), .busy(s_busy)
  );

  function automatic void push_job(input int np, input int pl);
    beat_t b;
    for (int p = 0; p < np; p++) begin
      for (int k = 0; k < pl; k++) begin
        b.d  = 2'(p);
        b.c  = 6'(k);
        b.pd = (k == pl - 1);
        sb.push_back(b);
      end
    end
  endfunction

  // drive inputs just after the falling edge, then sample once they have settled
  task automatic tick(input logic r, input logic s, input logic a, input logic sr);
    @(negedge clk);
    data_rdy = r;
    stall    = s;
    abort    = a;
    s_rdy    = sr;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; data_rdy = 1'b1; stall = 1'b0; abort = 1'b0;
    s_rdy = 1'b1; s_stall = 1'b0; s_abort = 1'b0;
    #3;
    total++;
    if ({dir, dir_counter, mult_en, pass_done, data_done, busy} !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs dir=%0d cnt=%0d en=%b pd=%b dd=%b busy=%b required all 0",
               dir, dir_counter, mult_en, pass_done, data_done, busy);
    end
    total++;
    if ({s_dir, s_cnt, s_men, s_pd, s_dd, s_busy} !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs_small dir=%0d en=%b dd=%b busy=%b required all 0", s_dir, s_men, s_dd, s_busy);
    end
    @(negedge clk);
    data_rdy = 1'b0; s_rdy = 1'b0;
    reset_n = 1'b1;
    tick(0, 0, 0, 0);
    total++;
    if (busy !== 1'b0 || mult_en !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b en=%b required 0/0", busy, mult_en);
    end
  endtask

  task automatic test_job(input int stall_n, input int exp_done);
    beat_t e, got;
    int done_at, beats, pds, left;
    logic s;
    sb.delete();
    push_job(4, 36);
    done_at = 0; beats = 0; pds = 0; left = stall_n;
    tick(1, 0, 0, 0);
    for (int c = 1; c <= 400 && (done_at == 0 || c <= done_at + 1); c++) begin
      s = (left > 0 && sb.size() > 0 && sb[0].d == 2'd2 && sb[0].c == 6'd17);
      tick(0, s, 0, 0);
      if (s) begin
        left--;
        total++;
        if (mult_en !== 1'b0 || pass_done !== 1'b0 || dir !== 2'd2 || dir_counter !== 6'd17) begin
          bad++;
          $display("FAIL stall_hold c=%0d en=%b pd=%b dir=%0d cnt=%0d required 0/0/2/17",
                   c, mult_en, pass_done, dir, dir_counter);
        end
      end
      if (mult_en === 1'b1) begin
        beats++;
        got = '{d: dir, c: dir_counter, pd: pass_done};
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL extra_beat c=%0d dir=%0d cnt=%0d", c, dir, dir_counter);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL beat c=%0d got dir=%0d cnt=%0d pd=%b required dir=%0d cnt=%0d pd=%b",
                     c, got.d, got.c, got.pd, e.d, e.c, e.pd);
          end
        end
      end
      if (pass_done === 1'b1) pds++;
      if (data_done === 1'b1 && done_at == 0) begin
        done_at = c;
        total++;
        if (busy !== 1'b1 || mult_en !== 1'b0) begin
          bad++;
          $display("FAIL done_cycle busy=%b en=%b required 1/0", busy, mult_en);
        end
      end else if (done_at != 0 && c == done_at + 1) begin
        total++;
        if (busy !== 1'b0 || data_done !== 1'b0) begin
          bad++;
          $display("FAIL busy_fall busy=%b dd=%b required 0/0", busy, data_done);
        end
      end
    end
    total++;
    if (done_at != exp_done) begin
      bad++;
      $display("FAIL done_latency got=%0d required=%0d", done_at, exp_done);
    end
    total++;
    if (beats != 144 || pds != 4 || sb.size() != 0) begin
      bad++;
      $display("FAIL beat_totals beats=%0d pd=%0d left=%0d required 144/4/0", beats, pds, sb.size());
    end
  endtask

  task automatic test_abort();
    beat_t e, got;
    logic a, hit;
    int extra;
    sb.delete();
    push_job(4, 36);
    hit = 1'b0;
    tick(1, 0, 0, 0);
    for (int c = 1; c <= 200 && !hit; c++) begin
      a = (sb.size() > 0 && sb[0].d == 2'd1 && sb[0].c == 6'd35);
      tick(0, 0, a, 0);
      if (a) begin
        hit = 1'b1;
        total++;
        if (mult_en !== 1'b0 || pass_done !== 1'b0 || dir !== 2'd1 || dir_counter !== 6'd35) begin
          bad++;
          $display("FAIL abort_cycle en=%b pd=%b dir=%0d cnt=%0d required 0/0/1/35",
                   mult_en, pass_done, dir, dir_counter);
        end
      end else if (mult_en === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        got = '{d: dir, c: dir_counter, pd: pass_done};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL abort_beat got dir=%0d cnt=%0d required dir=%0d cnt=%0d", got.d, got.c, e.d, e.c);
        end
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL abort_point_reached got=0 required=1");
    end
    tick(0, 0, 0, 0);
    total++;
    if (busy !== 1'b0 || dir !== 2'd0 || dir_counter !== 6'd0 || data_done !== 1'b0) begin
      bad++;
      $display("FAIL after_abort busy=%b dir=%0d cnt=%0d dd=%b required 0/0/0/0", busy, dir, dir_counter, data_done);
    end
    extra = 0;
    repeat (6) begin
      tick(0, 0, 0, 0);
      if (mult_en !== 1'b0 || data_done !== 1'b0 || busy !== 1'b0) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL quiet_after_abort active_cycles=%0d required=0", extra);
    end
  endtask

  task automatic test_async_reset();
    int extra;
    tick(1, 0, 0, 0);
    repeat (40) tick(0, 0, 0, 0);
    total++;
    if (busy !== 1'b1 || dir !== 2'd1) begin
      bad++;
      $display("FAIL pre_reset busy=%b dir=%0d required 1/1", busy, dir);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({dir, dir_counter, mult_en, pass_done, data_done, busy} !== 12'd0) begin
      bad++;
      $display("FAIL async_reset dir=%0d cnt=%0d en=%b busy=%b required all 0", dir, dir_counter, mult_en, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    extra = 0;
    repeat (10) begin
      tick(0, 0, 0, 0);
      if (busy !== 1'b0 || mult_en !== 1'b0 || data_done !== 1'b0) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL quiet_after_reset active_cycles=%0d required=0", extra);
    end
  endtask

  task automatic test_small();
    beat_t e, got;
    int done_at, beats, pds;
    sb.delete();
    push_job(3, 1);
    done_at = 0; beats = 0; pds = 0;
    tick(0, 0, 0, 1);
    for (int c = 1; c <= 10; c++) begin
      tick(0, 0, 0, 0);
      if (s_men === 1'b1) begin
        beats++;
        got = '{d: s_dir, c: {5'd0, s_cnt}, pd: s_pd};
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL small_extra_beat c=%0d dir=%0d", c, s_dir);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL small_beat c=%0d got dir=%0d cnt=%0d pd=%b required dir=%0d cnt=%0d pd=%b",
                     c, got.d, got.c, got.pd, e.d, e.c, e.pd);
          end
        end
      end
      if (s_pd === 1'b1) pds++;
      if (s_dd === 1'b1 && done_at == 0) done_at = c;
    end
    total++;
    if (done_at != 4 || beats != 3 || pds != 3) begin
      bad++;
      $display("FAIL small_job done=%0d beats=%0d pd=%0d required 4/3/3", done_at, beats, pds);
    end
  endtask

  task automatic test_back_to_back();
    int d1, m2, gap_req;
    logic busy_req;
`ifdef SEQ_AUTO_RESTART_EN
    gap_req = 1; busy_req = 1'b1;
`else
    gap_req = 2; busy_req = 1'b0;
`endif
    d1 = 0; m2 = 0;
    for (int c = 0; c <= 400 && m2 == 0; c++) begin
      tick(1, 0, 0, 0);
      if (d1 != 0 && c == d1 + 1) begin
        total++;
        if (busy !== busy_req) begin
          bad++;
          $display("FAIL gap_busy busy=%b required=%b", busy, busy_req);
        end
      end
      if (d1 != 0 && mult_en === 1'b1) begin
        m2 = c;
        total++;
        if (dir !== 2'd0 || dir_counter !== 6'd0) begin
          bad++;
          $display("FAIL restart_beat dir=%0d cnt=%0d required 0/0", dir, dir_counter);
        end
      end
      if (data_done === 1'b1 && d1 == 0) d1 = c;
    end
    total++;
    if (d1 == 0 || m2 - d1 != gap_req) begin
      bad++;
      $display("FAIL restart_gap done=%0d next_beat=%0d gap=%0d required gap=%0d", d1, m2, m2 - d1, gap_req);
    end
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_cleanup busy=%b required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_job(0, 145);
    test_job(5, 150);
    test_abort();
    test_async_reset();
    test_small();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_pass_sequencer.md
Name: mult_pass_sequencer

Overview:
- Parametrised successor to the fixed four-pass multiply control FSM.
- Sequences NUM_PASSES multiply passes of PASS_LEN beats each, and drives the operand-select index (dir) and the element address (dir_counter).
- Adds three things the fixed FSM lacks: a stall input, a synchronous abort, and per-pass and per-job completion strobes.
- Sits between the input-ready logic and the matrix-multiply datapath.

Parameters:
- NUM_PASSES, 4, number of passes per job (>=1).
- PASS_LEN, 36, beats per pass (>=1).
- DIR_W, max(1,$clog2(NUM_PASSES)), width of dir (derived; do not override).
- CNT_W, max(1,$clog2(PASS_LEN)), width of dir_counter (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- data_rdy  in  1  job start request, level-sampled in IDLE.
- stall  in  1  datapath back-pressure; holds the sequence when high.
- abort  in  1  synchronous job cancel.
- dir  out  DIR_W  current pass index, 0..NUM_PASSES-1.
- dir_counter  out  CNT_W  current beat index within the pass, 0..PASS_LEN-1.
- mult_en  out  1  beat valid: datapath consumes dir/dir_counter this cycle.
- pass_done  out  1  high on the last beat of each pass.
- data_done  out  1  one-cycle job-complete strobe.
- busy  out  1  high while in RUN or DONE.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, dir=0, dir_counter=0, data_done=0. Combinational outputs evaluate to 0.
- States: IDLE, RUN, DONE. state, dir, dir_counter and data_done are registered. mult_en, pass_done and busy are decoded from state and inputs.
- mult_en = (state==RUN) & !stall & !abort.
- pass_done = mult_en & (dir_counter==PASS_LEN-1).
- busy = (state!=IDLE).
- IDLE: dir=0, dir_counter=0. If data_rdy=1 and abort=0 at a clock edge, go to RUN with dir=0 and dir_counter=0.
- RUN, beat advance: occurs only when mult_en=1.
  - If dir_counter<PASS_LEN-1: dir_counter+1.
  - If dir_counter==PASS_LEN-1 and dir<NUM_PASSES-1: dir_counter wraps to 0, dir+1.
  - If on the last beat of the last pass: go to DONE, dir=0, dir_counter=0.
- RUN with stall=1: state, dir and dir_counter hold; no strobes.
- DONE: data_done=1 for exactly one cycle, then go to IDLE. stall has no effect in DONE.
- data_rdy is ignored outside IDLE (no queuing). A request held high through DONE starts a new job on the cycle after the return to IDLE.
- abort=1 in any state: next state is IDLE, dir and dir_counter clear to 0, data_done is not asserted. abort has priority over stall, data_rdy and the last beat.
- Latency with no stall: the data_rdy sampling edge is followed by NUM_PASSES*PASS_LEN RUN cycles, then one DONE cycle. data_done is high in cycle NUM_PASSES*PASS_LEN+1 after that edge. Each stall cycle in RUN adds exactly one cycle.
- PASS_LEN=1: dir_counter is always 0 and every beat is a pass_done beat.
- NUM_PASSES=1: dir is always 0.
- Counter comparisons are done at CNT_W/DIR_W width. Values above the terminal count never occur.
- reset_n asserted mid-job: immediate return to reset values. No data_done.

Optional Feature:
- Macro: SEQ_AUTO_RESTART_EN.
- Defined: in DONE, if data_rdy=1 and abort=0, go directly to RUN with dir=0 and dir_counter=0 (data_done is still asserted that cycle). This gives back-to-back jobs with no IDLE gap.
- Undefined: DONE always returns to IDLE, so there is a minimum one-cycle IDLE gap between jobs.

Test Plan (defaults 4/36 unless stated):
- Reset, then a one-cycle data_rdy pulse, no stall -> 144 mult_en cycles, dir stepping 0,1,2,3 at counter wrap 35->0. pass_done seen 4 times. data_done high exactly at cycle 145. busy falls the cycle after.
- Stall high for 5 cycles at dir=2, dir_counter=17 -> dir/dir_counter frozen, mult_en=0 throughout. data_done delayed to cycle 150.
- abort at dir=1, dir_counter=35 together with mult_en conditions -> IDLE next cycle, dir=0, dir_counter=0, no pass_done, no data_done.
- reset_n pulsed low mid-pass, asynchronously between edges -> outputs 0 immediately. After release, no activity until data_rdy.
- NUM_PASSES=3, PASS_LEN=1 -> 3 beats, each with pass_done=1, dir=0,1,2. data_done at cycle 4.
- data_rdy held high continuously -> jobs separated by one IDLE cycle (macro off), or by zero IDLE cycles with the next job starting on the cycle after DONE (SEQ_AUTO_RESTART_EN).
